// File: rtl/pipe_lane_reg.sv
// Multi-lane inter-stage pipeline register with per-lane valid, bubble/hold stall handling,
// exception and branch flush, and saturating bubble/flush event counters.
module pipe_lane_reg #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STAGE_IDX = 1,
    parameter bit          ZERO_KILL = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic                    flush_cause,
    input  logic [LANES-1:0]        kill_mask_i,
    input  logic [LANES-1:0]        valid_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    input  logic                    cnt_clr_i,
    output logic [LANES-1:0]        valid_o,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]        bubble_cnt_o,
    output logic [CNT_W-1:0]        flush_cnt_o
);

    typedef enum logic [1:0] {
        ActExcFlush,
        ActBubble,
        ActCapture,
        ActHold
    } act_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic                    up;
    logic                    dn;
    logic                    br_flush;
    logic [LANES-1:0]        ek;
    logic [LANES-1:0]        kill;
    act_e                    act;

    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES*DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]        bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;

    // Only the two boundary bits of the stall vector matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign up       = stall[STAGE_IDX];
    assign dn       = stall[STAGE_IDX+1];
    assign br_flush = flush & flush_cause;

    // A killed lane takes every younger lane with it: prefix-OR from lane 0 upward.
    always_comb begin
        logic acc;
        acc = 1'b0;
        ek  = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            acc   = acc | kill_mask_i[k];
            ek[k] = acc;
        end
    end

    assign kill = br_flush ? ek : '0;

    always_comb begin
        act = ActHold;
        if (flush && !flush_cause) begin
            act = ActExcFlush;
        end else if (up && !dn) begin
            act = ActBubble;
        end else if (!up) begin
            act = ActCapture;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        unique case (act)
            ActExcFlush, ActBubble: begin
                valid_d = '0;
                if (ZERO_KILL) begin
                    data_d = '0;
                end
            end
            ActCapture: begin
                valid_d = valid_i & ~kill;
                data_d  = data_i;
            end
            ActHold: begin
                valid_d = valid_q & ~kill;
            end
            default: ;
        endcase
        if (ZERO_KILL && (act == ActCapture || act == ActHold)) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (kill[k]) begin
                    data_d[k*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (cnt_clr_i) begin
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end else begin
            if (act == ActBubble && bubble_cnt_q != CntMax) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
            if (act == ActExcFlush && flush_cnt_q != CntMax) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            data_q       <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_lane_reg.sv
// Bench for pipe_lane_reg: a default instance and a CNT_W=2 / ZERO_KILL=0 instance share stimulus
// and are checked every cycle against a lane-level model plus directed literal expectations.
module tb_pipe_lane_reg;

    localparam int LANES = 2;
    localparam int DW    = 64;
    localparam int SW    = 6;
    localparam int STG   = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [SW-1:0]         stall = '0;
    logic                  flush = 1'b0;
    logic                  flush_cause = 1'b0;
    logic [LANES-1:0]      kill_mask = '0;
    logic [LANES-1:0]      valid_in = '0;
    logic [LANES*DW-1:0]   data_in = '0;
    logic                  cnt_clr = 1'b0;

    logic [LANES-1:0]      a_valid, b_valid;
    logic [LANES*DW-1:0]   a_data, b_data;
    logic [15:0]           a_bub, a_fl;
    logic [1:0]            b_bub, b_fl;

    int total = 0;
    int bad   = 0;

    // Model state per instance.
    logic [LANES-1:0]    ma_v, mb_v;
    logic [LANES*DW-1:0] ma_d, mb_d;
    int                  ma_bc, ma_fc, mb_bc, mb_fc;

    always #5 clk = ~clk;

    pipe_lane_reg #(
        .LANES(LANES), .DATA_W(DW), .STALL_W(SW), .STAGE_IDX(STG), .ZERO_KILL(1'b1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_cause(flush_cause),
        .kill_mask_i(kill_mask), .valid_i(valid_in), .data_i(data_in), .cnt_clr_i(cnt_clr),
        .valid_o(a_valid), .data_o(a_data), .bubble_cnt_o(a_bub), .flush_cnt_o(a_fl)
    );

    pipe_lane_reg #(
        .LANES(LANES), .DATA_W(DW), .STALL_W(SW), .STAGE_IDX(STG), .ZERO_KILL(1'b0), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_cause(flush_cause),
        .kill_mask_i(kill_mask), .valid_i(valid_in), .data_i(data_in), .cnt_clr_i(cnt_clr),
        .valid_o(b_valid), .data_o(b_data), .bubble_cnt_o(b_bub), .flush_cnt_o(b_fl)
    );

    task automatic chk(input string name, input logic [LANES*DW-1:0] act,
                       input logic [LANES*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane-level rule model: decide the action, then apply the kill boundary.
    task automatic model_step(input bit zk, input int cmax,
                              inout logic [LANES-1:0] v, inout logic [LANES*DW-1:0] d,
                              inout int bc, inout int fc);
        int  first_kill;
        bit  exc, bub;
        first_kill = LANES;
        if (flush && flush_cause) begin
            for (int k = LANES - 1; k >= 0; k--) begin
                if (kill_mask[k]) first_kill = k;
            end
        end
        exc = flush && !flush_cause;
        bub = !exc && stall[STG] && !stall[STG+1];
        if (exc || bub) begin
            v = '0;
            if (zk) d = '0;
        end else begin
            if (!stall[STG]) begin
                v = valid_in;
                d = data_in;
            end
            for (int k = first_kill; k < LANES; k++) begin
                v[k] = 1'b0;
                if (zk) d[k*DW +: DW] = '0;
            end
        end
        if (cnt_clr) begin
            bc = 0;
            fc = 0;
        end else begin
            if (exc && fc < cmax) fc++;
            if (bub && bc < cmax) bc++;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_v = '0; ma_d = '0; ma_bc = 0; ma_fc = 0;
            mb_v = '0; mb_d = '0; mb_bc = 0; mb_fc = 0;
        end else begin
            model_step(1'b1, 65535, ma_v, ma_d, ma_bc, ma_fc);
            model_step(1'b0, 3, mb_v, mb_d, mb_bc, mb_fc);
        end
    end

    always @(negedge clk) begin
        chk("model_a_valid", LANES*DW'(a_valid), LANES*DW'(ma_v));
        chk("model_a_data", a_data, ma_d);
        chk("model_a_bubble", LANES*DW'(a_bub), LANES*DW'(ma_bc));
        chk("model_a_flush", LANES*DW'(a_fl), LANES*DW'(ma_fc));
        chk("model_b_valid", LANES*DW'(b_valid), LANES*DW'(mb_v));
        chk("model_b_data", b_data, mb_d);
        chk("model_b_bubble", LANES*DW'(b_bub), LANES*DW'(mb_bc));
        chk("model_b_flush", LANES*DW'(b_fl), LANES*DW'(mb_fc));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [SW-1:0] st, input logic fl, input logic fc,
                         input logic [LANES-1:0] km, input logic [LANES-1:0] vi,
                         input logic [LANES*DW-1:0] di, input logic clr);
        stall = st; flush = fl; flush_cause = fc; kill_mask = km;
        valid_in = vi; data_in = di; cnt_clr = clr;
    endtask

    localparam logic [SW-1:0] StNone = 6'b000000;
    localparam logic [SW-1:0] StBub  = 6'b000010;
    localparam logic [SW-1:0] StHold = 6'b000110;
    localparam logic [SW-1:0] StDn   = 6'b000100;

    initial begin
        // T1: asynchronous reset with live inputs
        drive(StNone, 1'b0, 1'b0, 2'b00, 2'b11, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        #1 rst = 1'b0;
        #2;
        chk("t1_a_valid", LANES*DW'(a_valid), '0);
        chk("t1_a_data", a_data, '0);
        chk("t1_a_bubble", LANES*DW'(a_bub), '0);
        chk("t1_a_flush", LANES*DW'(a_fl), '0);
        chk("t1_b_valid", LANES*DW'(b_valid), '0);
        cyc();
        rst = 1'b1;

        // T2: capture
        drive(StNone, 1'b0, 1'b0, 2'b00, 2'b11, {64'hB, 64'hA}, 1'b0);
        cyc();
        chk("t2_valid", LANES*DW'(a_valid), LANES*DW'(2'b11));
        chk("t2_data", a_data, {64'hB, 64'hA});

        // T3: bubble, then a fresh capture held for three cycles
        drive(StBub, 1'b0, 1'b0, 2'b00, 2'b11, {64'h7, 64'h6}, 1'b0);
        cyc();
        chk("t3_bub_valid", LANES*DW'(a_valid), '0);
        chk("t3_bub_data", a_data, '0);
        chk("t3_bub_cnt", LANES*DW'(a_bub), LANES*DW'(1));
        chk("t3_b_data_kept", b_data, {64'hB, 64'hA});
        drive(StNone, 1'b0, 1'b0, 2'b00, 2'b11, {64'hD, 64'hC}, 1'b0);
        cyc();
        drive(StHold, 1'b0, 1'b0, 2'b11, 2'b01, {64'h9, 64'h8}, 1'b0);
        cyc(); cyc(); cyc();
        chk("t3_hold_valid", LANES*DW'(a_valid), LANES*DW'(2'b11));
        chk("t3_hold_data", a_data, {64'hD, 64'hC});
        chk("t3_hold_bub", LANES*DW'(a_bub), LANES*DW'(1));

        // T4: branch kill while holding
        drive(StHold, 1'b1, 1'b1, 2'b01, 2'b11, {64'h9, 64'h8}, 1'b0);
        cyc();
        chk("t4_k01_valid", LANES*DW'(a_valid), '0);
        chk("t4_k01_data", a_data, '0);
        drive(StNone, 1'b0, 1'b0, 2'b00, 2'b11, {64'hF, 64'hE}, 1'b0);
        cyc();
        drive(StHold, 1'b1, 1'b1, 2'b10, 2'b11, {64'h9, 64'h8}, 1'b0);
        cyc();
        chk("t4_k10_valid", LANES*DW'(a_valid), LANES*DW'(2'b01));
        chk("t4_k10_data", a_data, {64'h0, 64'hE});
        chk("t4_b_k10_data", b_data, {64'hF, 64'hE});

        // Branch kill during capture; downstream-only stall still captures
        drive(StDn, 1'b1, 1'b1, 2'b10, 2'b11, {64'h11, 64'h10}, 1'b0);
        cyc();
        chk("cap_kill_valid", LANES*DW'(a_valid), LANES*DW'(2'b01));
        chk("cap_kill_data", a_data, {64'h0, 64'h10});
        // Mask ignored without flush
        drive(StNone, 1'b0, 1'b1, 2'b01, 2'b11, {64'h13, 64'h12}, 1'b0);
        cyc();
        chk("mask_ignored", LANES*DW'(a_valid), LANES*DW'(2'b11));

        // T5: exception flush beats the bubble
        drive(StBub, 1'b1, 1'b0, 2'b00, 2'b11, {64'h15, 64'h14}, 1'b0);
        cyc();
        chk("t5_valid", LANES*DW'(a_valid), '0);
        chk("t5_flush_cnt", LANES*DW'(a_fl), LANES*DW'(1));
        chk("t5_bub_cnt", LANES*DW'(a_bub), LANES*DW'(1));

        // T6: saturation on the narrow instance, then clear beats increment
        drive(StBub, 1'b0, 1'b0, 2'b00, 2'b11, {64'h17, 64'h16}, 1'b0);
        repeat (5) cyc();
        chk("t6_b_sat", LANES*DW'(b_bub), LANES*DW'(3));
        chk("t6_a_cnt", LANES*DW'(a_bub), LANES*DW'(6));
        drive(StBub, 1'b0, 1'b0, 2'b00, 2'b11, {64'h17, 64'h16}, 1'b1);
        cyc();
        chk("t6_b_clr", LANES*DW'(b_bub), '0);
        chk("t6_a_clr", LANES*DW'(a_bub), '0);
        chk("t6_a_fl_clr", LANES*DW'(a_fl), '0);

        // Reset mid-stall, then capture on the first edge after release
        drive(StNone, 1'b0, 1'b0, 2'b00, 2'b10, {64'h21, 64'h20}, 1'b0);
        cyc();
        drive(StHold, 1'b0, 1'b0, 2'b00, 2'b11, {64'h23, 64'h22}, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst_valid", LANES*DW'(a_valid), '0);
        chk("midrst_b_data", b_data, '0);
        cyc();
        rst = 1'b1;
        drive(StNone, 1'b0, 1'b0, 2'b00, 2'b10, {64'h25, 64'h24}, 1'b0);
        cyc();
        chk("postrst_data", a_data, {64'h25, 64'h24});

        // Mixed random traffic, checked by the model only
        for (int i = 0; i < 60; i++) begin
            drive(SW'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
                  2'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 15) == 0));
            cyc();
        end

        @(posedge clk);
        #7;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
